// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_if
//  Purpose  : Instruction-memory bus between the fetch stage and the
//             instruction memory. The read is single-cycle combinational:
//             the word at i_inst_addr is presented on i_inst_rdata in the
//             same cycle, with no handshake.
//  Signals  : i_inst_addr  [31:0]  fetch address (driven by the fetch stage)
//             i_inst_rdata [31:0]  instruction word at i_inst_addr
//  Modports : master - fetch stage (drives address, reads data)
//             slave  - instruction memory (reads address, drives data)
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_stage_if;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;

  modport master (output i_inst_addr, input i_inst_rdata);
  modport slave  (input  i_inst_addr, output i_inst_rdata);
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Fetch stage of the 5-stage MIPS pipeline. Holds the program
//             counter, drives the instruction-memory address and captures
//             the fetched word into the F/D pipeline register. Branches are
//             delayed: the word fetched while the branch sits in D (the delay
//             slot) enters D normally and the redirect takes effect on the
//             following fetch.
//  Params   : RESET_PC  PC loaded on reset (first fetched address)
//  Ports    : clk      pipeline clock, rising edge
//             reset    synchronous active-high reset
//             stall    freeze PC and F/D register
//             branch   redirect request from D-stage next-PC logic
//             npc      redirect target, valid when branch=1
//             d_clear  load a bubble into F/D
//             imem     instruction-memory bus (master side)
//             f_pc     current fetch PC
//             d_instr  instruction in D (0 for bubbles / misaligned fetch)
//             d_pc     PC of the instruction in D
//             d_pc4    d_pc + 4
//             d_valid  D holds a real instruction
//             d_adel   D instruction came from a misaligned fetch address
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00003000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        stall,
  input  wire logic        branch,
  input  wire logic [31:0] npc,
  input  wire logic        d_clear,
  fetch_stage_if.master    imem,
  output logic      [31:0] f_pc,
  output logic      [31:0] d_instr,
  output logic      [31:0] d_pc,
  output logic      [31:0] d_pc4,
  output logic             d_valid,
  output logic             d_adel
);

  localparam logic [31:0] c_pc_step = 32'd4;
  localparam logic [31:0] c_nop     = 32'h0000_0000;

  logic [31:0] r_f_pc;
  logic [31:0] r_d_instr;
  logic [31:0] r_d_pc;
  logic [31:0] r_d_pc4;
  logic        r_d_valid;
  logic        r_d_adel;

  logic [31:0] w_f_pc4;
  logic [31:0] w_next_pc;
  logic        w_misaligned;

  // Sequential increment wraps naturally modulo 2^32.
  assign w_f_pc4      = r_f_pc + c_pc_step;
  // npc is taken as-is; a misaligned target is fetched and flagged in D.
  assign w_next_pc    = branch ? npc : w_f_pc4;
  assign w_misaligned = |r_f_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_f_pc    <= RESET_PC;
      r_d_instr <= c_nop;
      r_d_pc    <= 32'h0;
      r_d_pc4   <= 32'h0;
      r_d_valid <= 1'b0;
      r_d_adel  <= 1'b0;
    end else if (!stall) begin
      // PC advances whether or not D is being flushed.
      r_f_pc  <= w_next_pc;
      r_d_pc  <= r_f_pc;
      r_d_pc4 <= w_f_pc4;
      if (d_clear) begin
        r_d_instr <= c_nop;
        r_d_valid <= 1'b0;
        r_d_adel  <= 1'b0;
      end else begin
        // A misaligned fetch still occupies D as a valid slot so the
        // address-error exception can be raised against it; the word
        // itself is replaced by a nop.
        r_d_instr <= w_misaligned ? c_nop : imem.i_inst_rdata;
        r_d_valid <= 1'b1;
        r_d_adel  <= w_misaligned;
      end
    end
  end

  assign imem.i_inst_addr = r_f_pc;
  assign f_pc             = r_f_pc;
  assign d_instr          = r_d_instr;
  assign d_pc             = r_d_pc;
  assign d_pc4            = r_d_pc4;
  assign d_valid          = r_d_valid;
  assign d_adel           = r_d_adel;

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage of the 5-stage MIPS pipeline.
- Owns the program counter register, drives the instruction-memory address, and captures the fetched word into the F/D pipeline register.
- Consumes the redirect target (`npc`) and the `branch` flag produced by the D-stage next-PC logic.
- Supplies the D stage with `d_instr`, `d_pc` and `d_pc4`; `d_pc4` feeds back into next-PC computation.

Parameters:
- RESET_PC, 32'h00003000, PC value loaded on reset (first fetched address).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  from hazard unit; freezes PC and F/D register.
- branch  input  1  from D-stage next-PC logic; redirect request.
- npc  input  32  redirect target, valid when branch=1.
- d_clear  input  1  flush request; F/D loads a bubble.
- i_inst_addr  output  32  instruction-memory address (combinational = f_pc).
- i_inst_rdata  input  32  instruction word at i_inst_addr (combinational read).
- f_pc  output  32  current fetch PC.
- d_instr  output  32  instruction in D.
- d_pc  output  32  PC of instruction in D.
- d_pc4  output  32  d_pc + 4, registered.
- d_valid  output  1  D holds a real instruction (0 = bubble).
- d_adel  output  1  D instruction came from a misaligned fetch address.

Behaviour:
- Reset (reset=1 at edge, overrides everything):
  - f_pc <= RESET_PC.
  - d_instr, d_pc, d_pc4 <= 0.
  - d_valid, d_adel <= 0.
  - A reset asserted mid-stall or mid-branch discards all pending state.
- i_inst_addr = f_pc at all times; there is no memory handshake (the read is single-cycle combinational).
- Next PC when not stalled:
  - branch=1: f_pc <= npc.
  - Otherwise: f_pc <= f_pc + 4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
- F/D load when not stalled and d_clear=0:
  - d_pc <= f_pc, d_pc4 <= f_pc + 4, d_valid <= 1.
  - If f_pc[1:0] == 0: d_instr <= i_inst_rdata, d_adel <= 0.
  - If f_pc[1:0] != 0: d_instr <= 0 (nop), d_adel <= 1.
- Delayed branch:
  - branch is asserted while the branch/jump sits in D; the instruction fetched in that same cycle is the delay slot.
  - The delay slot enters D normally; the redirected PC takes effect in the following cycle.
  - Exactly one delay-slot instruction follows every taken branch.
- d_clear=1 and stall=0:
  - F/D loads a bubble: d_instr=0, d_valid=0, d_adel=0; d_pc and d_pc4 take f_pc and f_pc+4.
  - The PC still updates per the branch rule.
- stall=1:
  - f_pc and all D outputs hold their values.
  - branch and d_clear are ignored that cycle; the D instruction re-asserts them after the stall releases.
  - Priority: reset > stall > d_clear > normal load.
- Latency: one cycle from f_pc to the D outputs. No internal FSM beyond the PC and F/D registers; at most one outstanding fetch.
- npc is used unmodified, so a misaligned target is fetched and flagged (d_adel) rather than corrected.

Test Plan:
- Reset held 2 cycles, then released with sequential instructions -> f_pc = 0x3000, 0x3004, 0x3008 on successive cycles; d_pc lags f_pc by one cycle; d_pc4 = d_pc + 4; d_valid=1 from the second cycle after release.
- Taken branch: branch=1 with npc=0x3040 while f_pc=0x3010 -> D receives the 0x3010 delay slot; next cycle f_pc=0x3040; the instruction after that in D has d_pc=0x3040.
- Stall with branch: stall=1 for 3 cycles while branch=1 and npc=0x3100 -> f_pc and d_* frozen; after release with branch still 1, f_pc=0x3100.
- Flush: d_clear=1 with stall=0 at f_pc=0x3020 -> next cycle d_instr=0, d_valid=0, f_pc=0x3024. With d_clear=1 and stall=1 together -> state frozen, no bubble inserted.
- Misaligned redirect: branch=1 with npc=0x3042 -> f_pc=0x3042, i_inst_addr=0x3042; next cycle d_adel=1, d_instr=0, d_valid=1, d_pc=0x3042.
- Wrap and reset-in-flight:
  - f_pc forced via branch to 0xFFFFFFFC, no further branch -> next f_pc=0x00000000, d_pc4 for that instruction = 0.
  - reset asserted during a stall -> f_pc=0x3000 and d_valid=0 on the next edge.
